alarm_bank: RTL



---
 rtl/alarm_pkg.sv | 40 ++++
 rtl/alarm_bank_if.sv | 31 +++
 rtl/alarm_channel.sv | 117 +++++++++++
 rtl/alarm_bank.sv | 61 ++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types for the alarm bank: channel state, BCD time, and the snooze minute adder.
// Pure declarations; no clocked logic lives here.
package alarm_pkg;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        RINGING  = 2'd2,
        SNOOZED  = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
    } bcd_time_t;

    localparam bcd_time_t TIME_ZERO = '0;

    // Adds m (< 60) minutes to a valid BCD time, carrying into hours and wrapping 23 -> 00.
    function automatic bcd_time_t bcd_add_min(bcd_time_t t, int m);
        int        mins;
        int        hrs;
        bcd_time_t r;
        mins = int'(t.m1) * 10 + int'(t.m0) + m;
        hrs  = int'(t.h1) * 10 + int'(t.h0);
        if (mins >= 60) begin
            mins = mins - 60;
            hrs  = hrs + 1;
        end
        if (hrs >= 24) hrs = hrs - 24;
        r.h1 = 4'(hrs / 10);
        r.h0 = 4'(hrs % 10);
        r.m1 = 4'(mins / 10);
        r.m0 = 4'(mins % 10);
        return r;
    endfunction

endpackage

// File: rtl/alarm_bank_if.sv
// Bus between the clock datapath and the alarm bank: time digits, controls, ring status and LEDs.
// Level/pulse signalling only; there is no backpressure.
interface alarm_bank_if #(
    parameter int NUM_ALARMS = 2,
    parameter int SEL_W      = 1,
    parameter int LED_W      = 6
);
    logic                  sec_tick;
    logic [3:0]            h1;
    logic [3:0]            h0;
    logic [3:0]            m1;
    logic [3:0]            m0;
    logic                  set_stb;
    logic [SEL_W-1:0]      set_sel;
    logic [NUM_ALARMS-1:0] arm_en;
    logic                  dismiss;
    logic                  snooze;
    logic [NUM_ALARMS-1:0] ringing;
    logic                  any_ring;
    logic [LED_W-1:0]      alarm_led;

    modport master (
        output sec_tick, h1, h0, m1, m0, set_stb, set_sel, arm_en, dismiss, snooze,
        input  ringing, any_ring, alarm_led
    );

    modport slave (
        input  sec_tick, h1, h0, m1, m0, set_stb, set_sel, arm_en, dismiss, snooze,
        output ringing, any_ring, alarm_led
    );
endinterface

// File: rtl/alarm_channel.sv
// One alarm channel: stored time, registered compare with edge detect, FSM, ring counter (snooze: ALARM_SNOOZE_EN).
// Rings two cycles after the matching time appears; no backpressure.
module alarm_channel
    import alarm_pkg::*;
#(
    parameter int RING_TICKS = 10,
    parameter int SNOOZE_MIN = 5
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_tick,
    input  bcd_time_t i_time,
    input  logic      i_set,
    input  logic      i_arm,
    input  logic      i_dismiss,
    input  logic      i_snooze,
    output logic      o_ringing
);

    state_t     r_state;
    state_t     w_nxt;
    bcd_time_t  r_time;
    logic       r_match;
    logic       r_match_d;
    logic [7:0] r_cnt;
    logic       w_rise;
    logic       w_stop;
    logic       w_stay_ring;
    logic       w_snz_req;
    logic       w_srise;

    assign w_rise      = r_match & ~r_match_d;
    assign w_stop      = i_tick && ((r_cnt + 8'd1) == 8'(RING_TICKS));
    assign w_stay_ring = (r_state == RINGING) && (w_nxt == RINGING);

`ifdef ALARM_SNOOZE_EN
    bcd_time_t r_snz_time;
    logic      r_smatch;
    logic      r_smatch_d;

    assign w_snz_req = i_snooze;
    assign w_srise   = r_smatch & ~r_smatch_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snz_time <= TIME_ZERO;
            r_smatch   <= 1'b0;
            r_smatch_d <= 1'b0;
        end else begin
            if ((r_state == RINGING) && (w_nxt == SNOOZED))
                r_snz_time <= bcd_add_min(i_time, SNOOZE_MIN);
            r_smatch   <= (i_time == r_snz_time);
            r_smatch_d <= r_smatch;
        end
    end
`else
    logic w_unused_snz;
    assign w_unused_snz = i_snooze ^ (SNOOZE_MIN == 0);
    assign w_snz_req    = 1'b0;
    assign w_srise      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= DISARMED;
        else        r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        if (!i_arm) begin
            w_nxt = DISARMED;
        end else if (i_set) begin
            w_nxt = ARMED;
        end else begin
            unique case (r_state)
                DISARMED: w_nxt = ARMED;
                ARMED:    if (w_rise) w_nxt = RINGING;
                RINGING: begin
                    if (i_dismiss)      w_nxt = ARMED;
                    else if (w_snz_req) w_nxt = SNOOZED;
                    else if (w_stop)    w_nxt = ARMED;
                end
                SNOOZED: begin
                    if (i_dismiss)    w_nxt = ARMED;
                    else if (w_srise) w_nxt = RINGING;
                end
                default: w_nxt = DISARMED;
            endcase
        end
    end

    always_comb begin
        o_ringing = (r_state == RINGING);
    end

    // A set forces both compare stages high so the minute just captured cannot fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_time    <= TIME_ZERO;
            r_match   <= 1'b0;
            r_match_d <= 1'b0;
            r_cnt     <= 8'd0;
        end else begin
            if (i_set) begin
                r_time    <= i_time;
                r_match   <= 1'b1;
                r_match_d <= 1'b1;
            end else begin
                r_match   <= (i_time == r_time);
                r_match_d <= r_match;
            end
            if (w_stay_ring && i_tick) r_cnt <= r_cnt + 8'd1;
            else if (!w_stay_ring)     r_cnt <= 8'd0;
        end
    end

endmodule

// File: rtl/alarm_bank.sv
// NUM_ALARMS alarm channels sharing one blink phase and LED bus; snooze built only with ALARM_SNOOZE_EN.
// ringing lags the time digits by two cycles, alarm_led lags the phase by one; no backpressure.
module alarm_bank
    import alarm_pkg::*;
#(
    parameter int NUM_ALARMS = 2,
    parameter int SEL_W      = 1,
    parameter int LED_W      = 6,
    parameter int RING_TICKS = 10,
    parameter int SNOOZE_MIN = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    alarm_bank_if.slave  bus
);

    bcd_time_t             w_time;
    logic [NUM_ALARMS-1:0] w_set;
    logic [NUM_ALARMS-1:0] w_ring;
    logic                  w_any;
    logic                  r_phase;
    logic [LED_W-1:0]      r_led;

    assign w_time = {bus.h1, bus.h0, bus.m1, bus.m0};
    assign w_any  = |w_ring;

    for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_ch
        assign w_set[g] = bus.set_stb && (bus.set_sel == SEL_W'(g));

        alarm_channel #(
            .RING_TICKS (RING_TICKS),
            .SNOOZE_MIN (SNOOZE_MIN)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_tick    (bus.sec_tick),
            .i_time    (w_time),
            .i_set     (w_set[g]),
            .i_arm     (bus.arm_en[g]),
            .i_dismiss (bus.dismiss),
            .i_snooze  (bus.snooze),
            .o_ringing (w_ring[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= 1'b0;
            r_led   <= '0;
        end else begin
            if (!w_any)            r_phase <= 1'b0;
            else if (bus.sec_tick) r_phase <= ~r_phase;
            r_led <= {LED_W{r_phase & w_any}};
        end
    end

    assign bus.ringing   = w_ring;
    assign bus.any_ring  = w_any;
    assign bus.alarm_led = r_led;

endmodule
